// File: rtl/msg_scheduler_pkg.sv
// Shared SHA-256 definitions for the message schedule and compression core:
// word widths, round count, scheduler state encodings, sigma functions.
package msg_scheduler_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned LONG_W    = 64;
    localparam int unsigned ROUNDS    = 64;
    localparam int unsigned WIN_DEPTH = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_EXPAND = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // small sigma 0: ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // small sigma 1: ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

endpackage

// File: rtl/msg_sched_expand.sv
// Combinational schedule expansion: W_t from W[t-2], W[t-7], W[t-15], W[t-16].
module msg_sched_expand
    import msg_scheduler_pkg::*;
(
    input  logic [WORD_W-1:0] w_m2,
    input  logic [WORD_W-1:0] w_m7,
    input  logic [WORD_W-1:0] w_m15,
    input  logic [WORD_W-1:0] w_m16,
    output logic [WORD_W-1:0] w_new
);

    // Sum of the four schedule terms, modulo 2^32
    always_comb begin
        w_new = sigma1(w_m2) + w_m7 + sigma0(w_m15) + w_m16;
    end

endmodule

// File: rtl/msg_scheduler.sv
// SHA-256 message schedule generator. Loads 16 padded words from the padder,
// then expands W16..W63, emitting W0..W63 through a valid/ready output.
// Optional feature: define MSG_SCHED_IDX_EN to expose the w_idx port.
module msg_scheduler
    import msg_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] w_in,
    input  logic              w_in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] w_out,
    output logic              w_valid,
    input  logic              w_ready,
    output logic              done
`ifdef MSG_SCHED_IDX_EN
    ,
    output logic [5:0]        w_idx
`endif
);

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);
    localparam logic [5:0] LOAD_END = 6'(WIN_DEPTH - 1);

    logic [1:0]        state_q, state_d;
    logic [WORD_W-1:0] win_q [WIN_DEPTH];
    logic [WORD_W-1:0] win_d [WIN_DEPTH];
    logic [5:0]        t_q, t_d;
    logic              first_q, first_d;
    logic [WORD_W-1:0] w_out_q, w_out_d;
    logic              w_valid_q, w_valid_d;

    logic              out_free;
    logic              produce;
    logic [5:0]        next_idx;
    logic [WORD_W-1:0] new_word;
    logic [WORD_W-1:0] w_exp;

    // Window taps: win_q[15] is W[t-1], win_q[0] is W[t-16]
    msg_sched_expand u_expand (
        .w_m2  (win_q[14]),
        .w_m7  (win_q[9]),
        .w_m15 (win_q[1]),
        .w_m16 (win_q[0]),
        .w_new (w_exp)
    );

    // Next-state, window shift and output register logic.
    // t holds the index of the word on w_out; first marks that no word of the
    // block has been produced yet, so t never needs to count to 64.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        t_d       = t_q;
        first_d   = first_q;
        w_out_d   = w_out_q;
        w_valid_d = w_valid_q;
        produce   = 1'b0;
        new_word  = w_in;
        out_free  = !w_valid_q || w_ready;
        next_idx  = first_q ? 6'd0 : t_q + 6'd1;
        in_ready  = (state_q == ST_LOAD) && out_free;
        done      = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    t_d     = '0;
                    first_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (w_in_valid && in_ready) begin
                    produce  = 1'b1;
                    new_word = w_in;
                    if (next_idx == LOAD_END) begin
                        state_d = ST_EXPAND;
                    end
                end
            end
            ST_EXPAND: begin
                if (t_q != LAST_IDX) begin
                    if (out_free) begin
                        produce  = 1'b1;
                        new_word = w_exp;
                    end
                end else if (w_valid_q && w_ready) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (produce) begin
            for (int unsigned i = 0; i < WIN_DEPTH - 1; i++) begin
                win_d[i] = win_q[i + 1];
            end
            win_d[WIN_DEPTH - 1] = new_word;
            w_out_d   = new_word;
            w_valid_d = 1'b1;
            t_d       = next_idx;
            first_d   = 1'b0;
        end else if (w_valid_q && w_ready) begin
            w_valid_d = 1'b0;
        end
    end

    // State, window, counter and output registers with async active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            win_q     <= '{default: '0};
            t_q       <= '0;
            first_q   <= 1'b0;
            w_out_q   <= '0;
            w_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            t_q       <= t_d;
            first_q   <= first_d;
            w_out_q   <= w_out_d;
            w_valid_q <= w_valid_d;
        end
    end

    assign w_out   = w_out_q;
    assign w_valid = w_valid_q;
`ifdef MSG_SCHED_IDX_EN
    assign w_idx   = t_q;
`endif

endmodule
